ripple_count_sampler: RTL and testbench
=======================================

# ripple_count_sampler

Downstream consumer of the 4-bit asynchronous ripple counter. It brings the counter's output, which is asynchronous and may glitch, into the `clk` domain. It accepts only samples that are stable across consecutive cycles and converts each accepted change into a modulo delta. Deltas accumulate into a wide running total, and a threshold-crossing event is issued over a valid/ready handshake.

## Interface
- `CNT_W`, 4: width of the ripple counter value.
- `ACC_W`, 16: width of the accumulator, `threshold` and `evt_data`.
- `DOWN`, 0: source direction; 0 = up counter, 1 = down counter.

Ports:
- `clk`  in  1  sampling clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cnt_in`  in  CNT_W  ripple counter output; asynchronous to `clk`.
- `en`  in  1  accumulate enable.
- `clr`  in  1  synchronous clear; has priority over `en`.
- `threshold`  in  ACC_W  event threshold; quasi-static.
- `total`  out  ACC_W  running accumulated count.
- `overflow`  out  1  sticky; set when the accumulator wraps.
- `evt_valid`  out  1  event pending.
- `evt_data`  out  ACC_W  `total` value at the crossing.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_lost`  out  1  sticky; set when a crossing occurs while an event is already pending.

## Operation
- **Synchronizer.** Each bit of `cnt_in` passes through two flops, `s1` then `s2`. A third register `s3` holds the previous `s2`.
- **Qualified sample.** `q = s2`, valid only when `s2 == s3`. A cycle with unequal values is ignored.
- **Baseline register.** `last` (CNT_W bits) holds the last accepted value.
- **FSM states:**
  - `INIT`: on the first qualified sample, load `last = q` and add no delta; go to `RUN`.
  - `RUN`: on each qualified sample with `en = 1`:
    - `delta = (q - last) mod 2^CNT_W` when `DOWN = 0`.
    - `delta = (last - q) mod 2^CNT_W` when `DOWN = 1`.
    - `total <= total + delta`, wrapping mod 2^ACC_W.
    - `last <= q`.
  - `delta = 0` is legal: nothing changes.
  - `en = 0` in `RUN`: go to `INIT`. `total` holds and counts occurring while disabled are discarded.
- **Overflow.** Set `overflow` when `total + delta` carries out of ACC_W bits. It stays set until `clr` or reset.
- **Crossing.** A crossing is an update where old `total < threshold` and new `total >= threshold`. When `threshold = 0` a crossing is impossible and no event ever fires.
- **Event with nothing pending.** A crossing sets `evt_valid = 1` and `evt_data = new total`.
- **Event already pending.** A crossing sets `evt_lost` and leaves `evt_valid`/`evt_data` unchanged.
- **Handshake.** `evt_valid` and `evt_data` hold until an edge with `evt_valid & evt_ready`, then `evt_valid <= 0`. If a crossing occurs on that same accept edge, the new event loads: `evt_valid` stays 1, `evt_data` takes the new value, and `evt_lost` is not set.
- **Clear.** `clr = 1` zeroes `total`, `overflow`, `evt_valid`, `evt_data` and `evt_lost`, and forces `INIT`. The synchronizer flops keep running.
- **Source rate requirement.** The source must advance fewer than 2^CNT_W counts between qualified samples, i.e. fewer than 16 counts per 4 `clk` cycles at the default `CNT_W`. Faster input aliases silently; no detection is required.

## Timing
- **Reset values:** `total = 0`, `overflow = 0`, `evt_valid = 0`, `evt_data = 0`, `evt_lost = 0`; `s1`, `s2`, `s3`, `last` = 0; state `INIT`.
- **Latency.** With `cnt_in` stable before edge E0, `s2` updates at E1 and `s3` at E2. `total` reflects the change after edge E3: 3 edges from the first capture, 4 cycles worst case.
- **Event timing.** `evt_valid` rises on the same edge that `total` crosses `threshold`.
- **Deassertion.** `evt_valid` falls on the edge after which `evt_ready` was sampled high. Zero-cycle accept is allowed.
- **Reset mid-operation.** Asynchronous assertion forces the reset values immediately. After release the block behaves as from power-up: the first qualified sample is a baseline only.
- **Outputs.** All outputs are registered; there is no combinational path from `cnt_in` or `evt_ready`.

## Test plan
- **Up-count baseline and wrap.** Reset, `en = 1`, `DOWN = 0`, hold `cnt_in = 5`: `total` stays 0. Step `cnt_in` 5→9→3, each held 6 cycles: `total` = 4 then 14 (9→3 gives delta 10).
- **Glitch rejection.** `cnt_in` 0111→1000 with a one-cycle intermediate 1111: `total` increases by exactly 1. The 1111 value is never accepted.
- **Down-count.** `DOWN = 1`, `cnt_in` 15→14→…→0→15, one step per 5 cycles: `total = 16` at the end, with a delta of 1 per step.
- **Event handshake.**
  - `threshold = 10`, `evt_ready = 0`, drive 12 counts: `evt_valid = 1`, `evt_data = 10` or `12` depending on step granularity.
  - Apply `clr`, `threshold = 3`, steps of +2: the first event is at `total = 4`.
  - Further steps to 8 with `evt_ready = 0`: `evt_lost` stays 0, since no new crossing occurs.
  - `evt_ready = 1`: `evt_valid` drops after one edge.
- **Overflow and lost event.**
  - `ACC_W = 8`, `threshold = 250`, drive 260 counts without ready: `overflow = 1` and `total = 4`.
  - A second crossing at 250 sets `evt_lost = 1`.
- **Clear, enable and reset.**
  - `en = 0` during 7 counts: `total` unchanged.
  - Re-enable: the first sample is a baseline, then deltas resume.
  - `clr` for one cycle: all outputs 0.
  - Pulse `rst` low mid-count: outputs 0 immediately.

Source files
------------

// File: rtl/ripple_count_sampler_if.sv
// Bus between the ripple-counter sampler and its consumer: counter input,
// controls, running total and the threshold-event handshake.
interface ripple_count_sampler_if #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 16
);
    logic [CNT_W-1:0] cnt_in;
    logic             en;
    logic             clr;
    logic [ACC_W-1:0] threshold;
    logic [ACC_W-1:0] total;
    logic             overflow;
    logic             evt_valid;
    logic [ACC_W-1:0] evt_data;
    logic             evt_ready;
    logic             evt_lost;

    modport master (
        output cnt_in, en, clr, threshold, evt_ready,
        input  total, overflow, evt_valid, evt_data, evt_lost
    );

    modport slave (
        input  cnt_in, en, clr, threshold, evt_ready,
        output total, overflow, evt_valid, evt_data, evt_lost
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple counter into clk, accepts only stable samples,
// accumulates modulo deltas into a running total and raises threshold events.
module ripple_count_sampler #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 16,
    parameter bit DOWN  = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    ripple_count_sampler_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] s1, s2, s3, last, delta;
    logic [2:0]       vld;
    logic             qual, load_base, accum, crossing;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] total_nxt;

    // vld tracks synchronizer fill after reset so the reset zeros are never
    // mistaken for a stable counter sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            vld <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            s1  <= bus.cnt_in;
            s2  <= s1;
            s3  <= s2;
            vld <= {vld[1:0], 1'b1};
        end
    end

    assign qual      = vld[2] && (s2 == s3);
    assign delta     = DOWN ? (last - s2) : (s2 - last);
    assign sum       = {1'b0, bus.total} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta};
    assign total_nxt = sum[ACC_W-1:0];
    assign crossing  = (bus.total < bus.threshold) && (total_nxt >= bus.threshold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt = state;
        load_base = 1'b0;
        accum     = 1'b0;
        if (bus.clr) begin
            state_nxt = INIT;
        end else begin
            case (state)
                INIT: if (bus.en && qual) begin
                    load_base = 1'b1;
                    state_nxt = RUN;
                end
                RUN: begin
                    if (!bus.en)   state_nxt = INIT;
                    else if (qual) accum = 1'b1;
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last          <= '0;
            bus.total     <= '0;
            bus.overflow  <= 1'b0;
            bus.evt_valid <= 1'b0;
            bus.evt_data  <= '0;
            bus.evt_lost  <= 1'b0;
        end else if (bus.clr) begin
            bus.total     <= '0;
            bus.overflow  <= 1'b0;
            bus.evt_valid <= 1'b0;
            bus.evt_data  <= '0;
            bus.evt_lost  <= 1'b0;
        end else begin
            if (load_base) last <= s2;
            if (accum) begin
                last      <= s2;
                bus.total <= total_nxt;
                if (sum[ACC_W]) bus.overflow <= 1'b1;
            end
            // A crossing on the accept edge replaces the outgoing event instead of being lost.
            if (accum && crossing) begin
                if (bus.evt_valid && !bus.evt_ready) begin
                    bus.evt_lost <= 1'b1;
                end else begin
                    bus.evt_valid <= 1'b1;
                    bus.evt_data  <= total_nxt;
                end
            end else if (bus.evt_valid && bus.evt_ready) begin
                bus.evt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: up, down and 8-bit-accumulator instances,
// a scoreboard of expected totals, and direct checks of flags and events.
module tb_ripple_count_sampler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ripple_count_sampler_if #(.CNT_W(4), .ACC_W(16)) ua ();
    ripple_count_sampler_if #(.CNT_W(4), .ACC_W(16)) da ();
    ripple_count_sampler_if #(.CNT_W(4), .ACC_W(8))  oa ();

    ripple_count_sampler #(.CNT_W(4), .ACC_W(16), .DOWN(1'b0)) u_up (.clk(clk), .rst(rst), .bus(ua.slave));
    ripple_count_sampler #(.CNT_W(4), .ACC_W(16), .DOWN(1'b1)) u_dn (.clk(clk), .rst(rst), .bus(da.slave));
    ripple_count_sampler #(.CNT_W(4), .ACC_W(8),  .DOWN(1'b0)) u_ov (.clk(clk), .rst(rst), .bus(oa.slave));

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [15:0] m_tot[3];
    logic [3:0]  m_last[3];
    logic        m_en[3];
    logic [15:0] prev_tot[3];
    bit          mon_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_tot(input int i);
        case (i)
            0:       return ua.total;
            1:       return da.total;
            default: return {8'h00, oa.total};
        endcase
    endfunction

    // Every change of any total must match the next expected entry, in order.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] t;
                exp_t        e;
                t = get_tot(i);
                if (t !== prev_tot[i]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("sb_unexpected_%0d", i), t, prev_tot[i]);
                    end else begin
                        e = sb.pop_front();
                        check("sb_idx", i, e.idx);
                        check($sformatf("sb_total_%0d", i), t, e.val);
                    end
                    prev_tot[i] = t;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [15:0] v);
        exp_t e;
        e.idx = i;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic set_cnt(input int i, input logic [3:0] v);
        case (i)
            0:       ua.cnt_in = v;
            1:       da.cnt_in = v;
            default: oa.cnt_in = v;
        endcase
    endtask

    task automatic set_en(input int i, input logic v);
        case (i)
            0:       ua.en = v;
            1:       da.en = v;
            default: oa.en = v;
        endcase
        m_en[i] = v;
    endtask

    // Drive a new counter value, update the reference model, hold for `hold` cycles.
    task automatic step(input int i, input logic [3:0] v, input int hold);
        logic [3:0]  d4;
        logic [15:0] nt;
        set_cnt(i, v);
        if (m_en[i]) begin
            d4 = (i == 1) ? (m_last[i] - v) : (v - m_last[i]);
            nt = m_tot[i] + {12'h000, d4};
            if (i == 2) nt = nt & 16'h00ff;
            if (nt != m_tot[i]) push(i, nt);
            m_tot[i] = nt;
        end
        m_last[i] = v;
        wait_cyc(hold);
    endtask

    task automatic clr_up();
        ua.clr = 1'b1;
        if (m_tot[0] != 16'd0) push(0, 16'd0);
        m_tot[0] = 16'd0;
        wait_cyc(1);
        ua.clr = 1'b0;
        wait_cyc(3);
    endtask

    task automatic check_up_zero(input string tag);
        check({tag, "_total"}, ua.total, 0);
        check({tag, "_ovf"},   ua.overflow, 0);
        check({tag, "_valid"}, ua.evt_valid, 0);
        check({tag, "_data"},  ua.evt_data, 0);
        check({tag, "_lost"},  ua.evt_lost, 0);
    endtask

    initial begin
        logic [3:0] v;
        rst = 1'b0;
        ua.cnt_in = 4'd5;  ua.en = 1'b1; ua.clr = 1'b0; ua.threshold = 16'd0;  ua.evt_ready = 1'b0;
        da.cnt_in = 4'd15; da.en = 1'b1; da.clr = 1'b0; da.threshold = 16'd0;  da.evt_ready = 1'b0;
        oa.cnt_in = 4'd0;  oa.en = 1'b1; oa.clr = 1'b0; oa.threshold = 8'd250; oa.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_tot[i] = 16'd0;
            m_en[i] = 1'b1;
            prev_tot[i] = 16'd0;
        end
        m_last[0] = 4'd5; m_last[1] = 4'd15; m_last[2] = 4'd0;

        wait_cyc(2);
        check_up_zero("reset");
        rst = 1'b1;
        mon_on = 1'b1;

        // Up-count: the held 5 is only a baseline, then 5->9->3 wraps
        wait_cyc(8);
        check("baseline_total", ua.total, 0);
        step(0, 4'd9, 6);
        check("up_5_9", ua.total, 4);
        step(0, 4'd3, 6);
        check("up_9_3_wrap", ua.total, 14);
        check("thr0_no_event", ua.evt_valid, 0);

        // Glitch: 7 -> 15 for one cycle -> 8 must add exactly 1
        step(0, 4'd7, 6);
        ua.cnt_in = 4'd15;
        wait_cyc(1);
        step(0, 4'd8, 6);
        check("glitch_total", ua.total, 19);

        // Event at threshold 10, twelve counts in steps of 2, no ready
        ua.threshold = 16'd10;
        clr_up();
        for (int k = 1; k <= 6; k++) step(0, 4'(8 + 2 * k), 6);
        check("evt10_total", ua.total, 12);
        check("evt10_valid", ua.evt_valid, 1);
        check("evt10_data",  ua.evt_data, 10);
        check("evt10_lost",  ua.evt_lost, 0);

        // Threshold 3: first event at 4, further steps do not cross again
        ua.threshold = 16'd3;
        clr_up();
        check("clr_valid", ua.evt_valid, 0);
        check("clr_data",  ua.evt_data, 0);
        step(0, 4'd6, 6);
        step(0, 4'd8, 6);
        check("evt3_valid", ua.evt_valid, 1);
        check("evt3_data",  ua.evt_data, 4);
        step(0, 4'd10, 6);
        step(0, 4'd12, 6);
        check("evt3_total", ua.total, 8);
        check("evt3_nolost", ua.evt_lost, 0);
        check("evt3_hold",  ua.evt_data, 4);
        ua.evt_ready = 1'b1;
        wait_cyc(1);
        check("accept_drop", ua.evt_valid, 0);
        ua.evt_ready = 1'b0;

        // Disabled counts are discarded; re-enable rebaselines
        set_en(0, 1'b0);
        for (int k = 1; k <= 7; k++) step(0, 4'(12 + k), 5);
        check("en0_total", ua.total, 8);
        set_en(0, 1'b1);
        wait_cyc(6);
        check("reen_baseline", ua.total, 8);
        step(0, 4'd6, 6);
        check("reen_delta", ua.total, 11);
        clr_up();
        check_up_zero("clr");

        // Down-count 15 -> 0 -> 15, one count per step
        for (int k = 14; k >= 0; k--) step(1, 4'(k), 5);
        step(1, 4'd15, 5);
        check("down_total", da.total, 16);
        check("down_no_event", da.evt_valid, 0);

        // 8-bit accumulator: 260 counts wrap to 4, then a second crossing is lost
        v = 4'd0;
        for (int k = 1; k <= 25; k++) begin
            v = v + 4'd10;
            step(2, v, 5);
        end
        check("ov_evt_valid", oa.evt_valid, 1);
        check("ov_evt_data",  oa.evt_data, 250);
        check("ov_pre_ovf",   oa.overflow, 0);
        v = v + 4'd10;
        step(2, v, 5);
        check("ov_wrap_total", oa.total, 4);
        check("ov_flag",       oa.overflow, 1);
        for (int k = 1; k <= 24; k++) begin
            v = v + 4'd10;
            step(2, v, 5);
        end
        check("ov_pre2_lost", oa.evt_lost, 0);
        v = v + 4'd6;
        step(2, v, 5);
        check("ov_total250", oa.total, 250);
        check("ov_lost",     oa.evt_lost, 1);
        check("ov_data_kept", oa.evt_data, 250);

        // Asynchronous reset mid-count
        step(0, 4'd8, 6);
        check("pre_rst_total", ua.total, 2);
        for (int i = 0; i < 3; i++) begin
            if (m_tot[i] != 16'd0) push(i, 16'd0);
            m_tot[i] = 16'd0;
        end
        rst = 1'b0;
        #2;
        check_up_zero("async_rst");
        check("async_rst_dn_total", da.total, 0);
        check("async_rst_ov_ovf",   oa.overflow, 0);
        check("async_rst_ov_lost",  oa.evt_lost, 0);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(8);
        check("post_rst_baseline", ua.total, 0);
        step(0, 4'd9, 6);
        check("post_rst_delta", ua.total, 1);

        wait_cyc(4);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
